alu_exec_unit: RTL and testbench

//  Execute-stage ALU that consumes the 4-bit ALU control code from the ALU control decoder and produces the result.
//  It also produces the branch/jump flags. Sits between decode/register-read and the memory/writeback stages.

---
 rtl/alu_ctrl_pkg.sv | 16 +
 rtl/alu_exec_unit_if.sv | 26 ++
 rtl/alu_shift_seq.sv | 30 +++
 rtl/alu_exec_unit.sv | 105 ++++++++++
 tb/tb_alu_exec_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: AluCtrl encodings shared with the control decoder, plus the ALU FSM state type
package alu_ctrl_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ANDI = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDI = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LW   = 4'b1000;
  localparam logic [3:0] ALU_SW   = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_JAL  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_JR   = 4'b1111;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: valid/ready operation and result bundle for the execute-stage ALU
interface alu_exec_unit_if #(parameter int DATA_WIDTH = 32);
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  logic                  InValid;
  logic                  InReady;
  logic [3:0]            AluCtrl;
  logic [DATA_WIDTH-1:0] OperandA;
  logic [DATA_WIDTH-1:0] OperandB;
  logic [SHAMT_W-1:0]    Shamt;
  logic [DATA_WIDTH-1:0] PcPlus4;
  logic                  OutValid;
  logic                  OutReady;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Zero;
  logic                  BranchTaken;
  logic                  JumpReg;
  logic                  IllegalOp;
  modport slave (
    input  InValid, AluCtrl, OperandA, OperandB, Shamt, PcPlus4, OutReady,
    output InReady, OutValid, Result, Zero, BranchTaken, JumpReg, IllegalOp
  );
  modport master (
    output InValid, AluCtrl, OperandA, OperandB, Shamt, PcPlus4, OutReady,
    input  InReady, OutValid, Result, Zero, BranchTaken, JumpReg, IllegalOp
  );
endinterface

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: one-bit-per-cycle left shifter; first bit shifts on start, done is asserted with the final bit
module alu_shift_seq #(
  parameter int DATA_WIDTH = 32,
  localparam int SHAMT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SHAMT_W-1:0]    shamt,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [SHAMT_W-1:0]    cnt;
  logic [DATA_WIDTH-1:0] val;
  assign done     = cnt == SHAMT_W'(1);
  assign data_out = {val[DATA_WIDTH-2:0], 1'b0};
  // load shifted-once operand on start, then shift and count down until the last step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      val <= '0;
    end else if (start) begin
      cnt <= shamt - 1'b1;
      val <= {data_in[DATA_WIDTH-2:0], 1'b0};
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      val <= {val[DATA_WIDTH-2:0], 1'b0};
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with one registered output slot; ALU_BARREL_SHIFT_EN selects a single-cycle SLL
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  logic                  ready_en;
  logic                  idle;
  logic                  acc;
  logic                  iter_sll;
  logic                  seq_done;
  logic [DATA_WIDTH-1:0] seq_data;
  logic [DATA_WIDTH-1:0] shl;
  logic [DATA_WIDTH-1:0] res;
  logic                  br;
  logic                  jr;
  logic                  ill;
`ifdef ALU_BARREL_SHIFT_EN
  assign idle     = 1'b1;
  assign iter_sll = 1'b0;
  assign seq_done = 1'b0;
  assign seq_data = '0;
  assign shl      = bus.OperandB << bus.Shamt;
`else
  state_t state, next_state;
  assign idle     = state == IDLE;
  assign iter_sll = bus.AluCtrl == ALU_SLL && |bus.Shamt[SHAMT_W-1:1];
  assign shl      = bus.Shamt[0] ? {bus.OperandB[DATA_WIDTH-2:0], 1'b0} : bus.OperandB;
  alu_shift_seq #(.DATA_WIDTH(DATA_WIDTH)) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (acc && iter_sll),
    .shamt   (bus.Shamt),
    .data_in (bus.OperandB),
    .done    (seq_done),
    .data_out(seq_data)
  );
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  // enter SHIFT on a multi-step SLL, leave when the shifter finishes
  always_comb begin
    next_state = state;
    next_state = (state == IDLE) ? ((acc && iter_sll) ? SHIFT : IDLE) : (seq_done ? IDLE : SHIFT);
  end
`endif
  assign acc         = bus.InValid && bus.InReady;
  assign bus.InReady = ready_en && idle && (!bus.OutValid || bus.OutReady);
  assign bus.Zero    = bus.OutValid && bus.Result == '0;
  // single-cycle op mux; only the flag owned by the code is raised
  always_comb begin
    res = '0;
    br  = 1'b0;
    jr  = 1'b0;
    ill = 1'b0;
    case (bus.AluCtrl)
      ALU_AND, ALU_ANDI:              res = bus.OperandA & bus.OperandB;
      ALU_ADD, ALU_ADDI, ALU_LW, ALU_SW: res = bus.OperandA + bus.OperandB;
      ALU_SLL:                        res = shl;
      ALU_SLT:                        res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.OperandA) < $signed(bus.OperandB)};
      ALU_BEQ: begin
        res = bus.OperandA - bus.OperandB;
        br  = bus.OperandA == bus.OperandB;
      end
      ALU_JAL:                        res = bus.PcPlus4;
      ALU_NOR:                        res = ~(bus.OperandA | bus.OperandB);
      ALU_JR: begin
        res = bus.OperandA;
        jr  = 1'b1;
      end
      default:                        ill = 1'b1;
    endcase
  end
  // output slot: shifter completion, else a 1-cycle accept (reload on drain), else drain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ready_en        <= 1'b0;
      bus.OutValid    <= 1'b0;
      bus.Result      <= '0;
      bus.BranchTaken <= 1'b0;
      bus.JumpReg     <= 1'b0;
      bus.IllegalOp   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (seq_done) begin
        bus.OutValid    <= 1'b1;
        bus.Result      <= seq_data;
        bus.BranchTaken <= 1'b0;
        bus.JumpReg     <= 1'b0;
        bus.IllegalOp   <= 1'b0;
      end else if (acc && !iter_sll) begin
        bus.OutValid    <= 1'b1;
        bus.Result      <= res;
        bus.BranchTaken <= br;
        bus.JumpReg     <= jr;
        bus.IllegalOp   <= ill;
      end else if (bus.OutReady) bus.OutValid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a behavioural model
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_exec_unit_if #(.DATA_WIDTH(32)) bus ();
  alu_exec_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [31:0] pc);
    case (c)
      4'd0, 4'd1:             return a & b;
      4'd2, 4'd3, 4'd8, 4'd9: return a + b;
      4'd4:                   return b << sh;
      4'd7:                   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10:                  return a - b;
      4'd11:                  return pc;
      4'd12:                  return ~(a | b);
      4'd15:                  return a;
      default:                return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [4:0] sh);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return (c == 4'd4 && sh > 5'd1) ? int'(sh) : 1;
`endif
  endfunction

  task automatic scramble();
    bus.AluCtrl  = 4'($urandom);
    bus.OperandA = $urandom;
    bus.OperandB = $urandom;
    bus.Shamt    = 5'($urandom);
    bus.PcPlus4  = $urandom;
  endtask

  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] pc, input string name);
    logic [31:0] er;
    logic eb, ej, ei;
    int lat, cyc, n;
    er  = model_res(c, a, b, sh, pc);
    eb  = (c == 4'd10) && (a == b);
    ej  = c == 4'd15;
    ei  = !(c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15});
    lat = model_lat(c, sh);
    bus.OutReady = 1'b1;
    n = 0;
    #1;
    while (!bus.InReady && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.InReady !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: InReady=%b required 1", name, bus.InReady);
    end
    bus.InValid  = 1'b1;
    bus.AluCtrl  = c;
    bus.OperandA = a;
    bus.OperandB = b;
    bus.Shamt    = sh;
    bus.PcPlus4  = pc;
    @(posedge clk);
    @(negedge clk);
    bus.InValid = 1'b0;
    scramble();
    cyc = 1;
    while (bus.OutValid !== 1'b1 && cyc < 64) begin
      checks++;
      if (bus.InReady !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_ready: cycle %0d InReady=%b required 0", name, cyc, bus.InReady);
      end
      @(negedge clk);
      scramble();
      cyc++;
    end
    checks++;
    if (cyc != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, cyc, lat);
    end
    checks++;
    if (bus.Result !== er) begin
      errors++;
      $display("FAIL %s result: got %h required %h", name, bus.Result, er);
    end
    checks++;
    if (bus.Zero !== (er == 32'd0)) begin
      errors++;
      $display("FAIL %s zero: got %b required %b", name, bus.Zero, er == 32'd0);
    end
    checks++;
    if ({bus.BranchTaken, bus.JumpReg, bus.IllegalOp} !== {eb, ej, ei}) begin
      errors++;
      $display("FAIL %s flags(br,jr,ill): got %b required %b", name,
               {bus.BranchTaken, bus.JumpReg, bus.IllegalOp}, {eb, ej, ei});
    end
  endtask

  task automatic test_reset();
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    scramble();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.OutValid, bus.Result, bus.Zero, bus.BranchTaken, bus.JumpReg, bus.IllegalOp} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: OutValid=%b Result=%h Zero=%b flags=%b required all 0", bus.OutValid,
               bus.Result, bus.Zero, {bus.BranchTaken, bus.JumpReg, bus.IllegalOp});
    end
    checks++;
    if (bus.InReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_inready: got %b required 0", bus.InReady);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.InReady !== 1'b0) begin
      errors++;
      $display("FAIL release_inready: got %b required 0 before first edge", bus.InReady);
    end
    @(negedge clk);
    checks++;
    if (bus.InReady !== 1'b1) begin
      errors++;
      $display("FAIL post_release_inready: got %b required 1", bus.InReady);
    end
  endtask

  task automatic test_basic_ops();
    do_op(4'b0010, 32'd5, 32'd7, 5'd0, 32'd0, "add_5_7");
    do_op(4'b1010, 32'h1234, 32'h1234, 5'd0, 32'd0, "beq_equal");
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, "slt_signed");
    do_op(4'b0101, $urandom, $urandom, 5'd0, 32'd0, "illegal_0101");
    do_op(4'b1111, 32'h400, $urandom, 5'd0, 32'd0, "jr");
    do_op(4'b1011, $urandom, $urandom, 5'd0, 32'h104, "jal");
  endtask

  task automatic test_sll();
    do_op(4'b0100, $urandom, 32'd1, 5'd31, 32'd0, "sll_31");
    do_op(4'b0100, $urandom, 32'd1, 5'd0, 32'd0, "sll_0");
    do_op(4'b0100, $urandom, 32'hA5A5_0F0F, 5'd1, 32'd0, "sll_1");
    do_op(4'b0100, $urandom, 32'hA5A5_0F0F, 5'd2, 32'd0, "sll_2");
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    bus.OutReady = 1'b1;
    bus.InValid  = 1'b1;
    bus.AluCtrl  = 4'b1100;
    bus.OperandA = 32'd0;
    bus.OperandB = 32'd0;
    @(posedge clk);
    @(negedge clk);
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    scramble();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.OutValid !== 1'b1 || bus.Result !== 32'hFFFF_FFFF || bus.InReady !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: OutValid=%b Result=%h InReady=%b required 1 ffffffff 0", i, bus.OutValid,
                 bus.Result, bus.InReady);
      end
      @(negedge clk);
    end
    a = $urandom;
    b = $urandom;
    bus.InValid  = 1'b1;
    bus.AluCtrl  = 4'b0000;
    bus.OperandA = a;
    bus.OperandB = b;
    bus.OutReady = 1'b1;
    #1;
    checks++;
    if (bus.InReady !== 1'b1) begin
      errors++;
      $display("FAIL drain_inready: got %b required 1", bus.InReady);
    end
    @(negedge clk);
    bus.InValid = 1'b0;
    checks++;
    if (bus.OutValid !== 1'b1 || bus.Result !== (a & b)) begin
      errors++;
      $display("FAIL reload_and: OutValid=%b Result=%h required 1 %h", bus.OutValid, bus.Result, a & b);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic seen;
    bus.OutReady = 1'b1;
    bus.InValid  = 1'b1;
    bus.AluCtrl  = 4'b0100;
    bus.OperandB = $urandom | 32'd1;
    bus.Shamt    = 5'd20;
    @(posedge clk);
    @(negedge clk);
    bus.InValid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b0 || bus.Result !== 32'd0) begin
      errors++;
      $display("FAIL abort_outputs: OutValid=%b InReady=%b Result=%h required 0 0 0", bus.OutValid,
               bus.InReady, bus.Result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: InReady=%b OutValid=%b required 1 0", bus.InReady, bus.OutValid);
    end
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= bus.OutValid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_stale: OutValid seen=%b required 0", seen);
    end
  endtask

  task automatic test_random();
    logic [3:0] c;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_op(c, a, b, 5'($urandom), $urandom, $sformatf("rand_%0d_op%0d", i, c));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_ops();
    test_sll();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
